key_sequencer: RTL and testbench

Transmit keying sequencer fed by the per-input deglitchers on the PTT, CW dot and CW dash lines. It merges the three clean levels into a single key request and raises `tx_on` while the key is active. After release, it holds `tx_on` for a programmable hang time in milliseconds, and it emits single-cycle edge pulses for the command/status path. The block sits between the deglitch stages and the TX control/status register logic.

---
 rtl/hpsdr_pkg.sv | 13 +
 rtl/ms_prescaler.sv | 28 ++
 rtl/key_sequencer.sv | 106 ++++++++++
 tb/tb_key_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpsdr_pkg.sv
// Shared types and default constants for the keying/TX-control path.
package hpsdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEYED = 2'd1,
    HANG  = 2'd2
  } key_state_t;

  localparam int KEY_PRESCALE_48M = 48000;
  localparam int KEY_HANG_W       = 8;

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond tick generator: counts 0..PRESCALE-1 while enabled, tick on the last count.
module ms_prescaler #(
  parameter int PRESCALE = 48000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Tick is combinational so the consumer acts in the same cycle the count hits LAST.
  assign tick = en & (cnt == LAST);

  // Counter runs only while enabled; any disabled cycle or explicit clear parks it at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (clr || !en)   cnt <= '0;
    else if (tick)         cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/key_sequencer.sv
// TX keying sequencer: merges PTT/dot/dash into one key, holds tx_on through a ms hang time.
module key_sequencer
  import hpsdr_pkg::*;
#(
  parameter int PRESCALE = KEY_PRESCALE_48M,
  parameter int HANG_W   = KEY_HANG_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ptt_in,
  input  logic              dot_in,
  input  logic              dash_in,
  input  logic [HANG_W-1:0] hang_ms,
  output logic              tx_on,
  output logic              cw_key,
  output logic              hang_active,
  output logic              key_rise,
  output logic              key_fall
);

  key_state_t        state_q, state_n;
  logic              key_q, key_d;
  logic [HANG_W-1:0] hang_cnt;
  logic              hang_load, hang_dec;
  logic              presc_clr, presc_en, tick;

  // Key sampling and edge pulses; edges are taken between key_q and its delayed copy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= 1'b0;
      key_d    <= 1'b0;
      cw_key   <= 1'b0;
      key_rise <= 1'b0;
      key_fall <= 1'b0;
    end else begin
      key_q    <= ptt_in | dot_in | dash_in;
      key_d    <= key_q;
      cw_key   <= dot_in | dash_in;
      key_rise <= key_q & ~key_d;
      key_fall <= ~key_q & key_d;
    end
  end

  assign presc_en  = (state_q == HANG);
  assign presc_clr = hang_load;

  ms_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (presc_clr),
    .en      (presc_en),
    .tick    (tick)
  );

  // Next-state logic; a re-key in HANG wins over an expiring tick.
  always_comb begin
    state_n   = state_q;
    hang_load = 1'b0;
    hang_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_q) state_n = KEYED;
      end
      KEYED: begin
        if (!key_q) begin
          if (hang_ms == '0) begin
            state_n = IDLE;
          end else begin
            state_n   = HANG;
            hang_load = 1'b1;
          end
        end
      end
      HANG: begin
        if (key_q) begin
          state_n = KEYED;
        end else if (tick) begin
          if (hang_cnt <= HANG_W'(1)) state_n = IDLE;
          else                        hang_dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with outputs registered from next-state so they line up with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_on       <= 1'b0;
      hang_active <= 1'b0;
    end else begin
      state_q     <= state_n;
      tx_on       <= (state_n != IDLE);
      hang_active <= (state_n == HANG);
    end
  end

  // Hang counter: hang_ms captured once on entry to HANG, then counted down per ms tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       hang_cnt <= '0;
    else if (hang_load) hang_cnt <= hang_ms;
    else if (hang_dec)  hang_cnt <= hang_cnt - HANG_W'(1);
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer with PRESCALE=4: vector table, corner sequences, random vs model.
module tb_key_sequencer;

  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ptt_in = 1'b0, dot_in = 1'b0, dash_in = 1'b0;
  logic [7:0] hang_ms = 8'd0;
  logic       tx_on, cw_key, hang_active, key_rise, key_fall;

  int n_err = 0;
  int n_chk = 0;

  key_sequencer #(.PRESCALE(P), .HANG_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ptt_in      (ptt_in),
    .dot_in      (dot_in),
    .dash_in     (dash_in),
    .hang_ms     (hang_ms),
    .tx_on       (tx_on),
    .cw_key      (cw_key),
    .hang_active (hang_active),
    .key_rise    (key_rise),
    .key_fall    (key_fall)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference model: key is "held" or a countdown of remaining hang cycles.
  bit m_kq, m_kd, m_keyed;
  int m_left;
  bit m_tx, m_cw, m_ha, m_rise, m_fall;

  task automatic model_reset();
    m_kq = 0; m_kd = 0; m_keyed = 0; m_left = 0;
    m_tx = 0; m_cw = 0; m_ha = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_edge();
    m_rise = m_kq & ~m_kd;
    m_fall = ~m_kq & m_kd;
    if (m_kq) begin
      m_keyed = 1; m_left = 0;
    end else if (m_keyed) begin
      m_keyed = 0; m_left = int'(hang_ms) * P;
    end else if (m_left > 0) begin
      m_left--;
    end
    m_tx = m_keyed || (m_left > 0);
    m_ha = !m_keyed && (m_left > 0);
    m_kd = m_kq;
    m_kq = ptt_in | dot_in | dash_in;
    m_cw = dot_in | dash_in;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({tx_on, cw_key, hang_active, key_rise, key_fall});
  endfunction

  // One clock: advance model at the edge, sample DUT 1 time unit later.
  task automatic cyc();
    @(posedge clock);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    chk("model{tx,cw,ha,rise,fall}", outs(), int'({m_tx, m_cw, m_ha, m_rise, m_fall}));
  endtask

  typedef struct {
    logic       ptt, dot, dash;
    logic [7:0] hang;
    logic [4:0] exp;   // {tx_on, cw_key, hang_active, key_rise, key_fall}
  } vec_t;

  vec_t tbl[12];

  int ha_n, fall_n, rise_n, bad_n, seen;

  initial begin
    // 1-cycle dot pulse, then overlapping PTT+dash, hang 0.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'd0, 5'b01000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b10010};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b00001};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b00000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd0, 5'b00000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'd0, 5'b10010};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd0, 5'b11000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'd0, 5'b11000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd0, 5'b11000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b10000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b00001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 5'b00000};

    model_reset();

    // Reset held with PTT active: everything stays low.
    ptt_in = 1'b1;
    #2;
    chk("reset_outs_async", outs(), 0);
    repeat (3) cyc();
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    cyc();
    chk("rel+1_tx", int'(tx_on), 0);
    cyc();
    chk("rel+2_tx", int'(tx_on), 1);
    chk("rel+2_rise", int'(key_rise), 1);
    cyc();
    chk("rel+3_rise", int'(key_rise), 0);
    ptt_in = 1'b0;
    repeat (4) cyc();

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      ptt_in = tbl[i].ptt; dot_in = tbl[i].dot; dash_in = tbl[i].dash; hang_ms = tbl[i].hang;
      cyc();
      chk($sformatf("tbl[%0d]", i), outs(), int'(tbl[i].exp));
    end

    // Basic PTT, no hang: 10 cycles in -> 10 cycles of tx_on.
    ha_n = 0; fall_n = 0; rise_n = 0; bad_n = 0;
    ptt_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) ptt_in = 1'b0;
      cyc();
      bad_n  += int'(tx_on);
      ha_n   += int'(hang_active);
      rise_n += int'(key_rise);
      fall_n += int'(key_fall);
    end
    chk("ptt_tx_cycles", bad_n, 10);
    chk("ptt_hang_active", ha_n, 0);
    chk("ptt_rise_n", rise_n, 1);
    chk("ptt_fall_n", fall_n, 1);

    // Hang expiry: 3 ms -> 12 cycles of hang_active, tx_on falls with it.
    hang_ms = 8'd3;
    dot_in = 1'b1;
    repeat (5) cyc();
    dot_in = 1'b0;
    ha_n = 0; fall_n = 0; bad_n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      ha_n   += int'(hang_active);
      fall_n += int'(key_fall);
      if (hang_active && !tx_on) bad_n++;
      if (i > 2 && !hang_active && tx_on) bad_n++;
    end
    chk("hang3_cycles", ha_n, 12);
    chk("hang3_fall_n", fall_n, 1);
    chk("hang3_tx_vs_ha", bad_n, 0);
    chk("hang3_tx_end", int'(tx_on), 0);

    // Re-key after 7 cycles of HANG: tx_on continuous, fresh reload of 20 cycles.
    hang_ms = 8'd5;
    dash_in = 1'b1;
    repeat (4) cyc();
    dash_in = 1'b0;
    bad_n = 0; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cyc();
      if (!tx_on) bad_n++;
      seen = int'(hang_active);
    end
    chk("rekey_hang_entered", seen, 1);
    repeat (6) begin
      cyc();
      if (!tx_on) bad_n++;
    end
    chk("rekey_still_hang", int'(hang_active), 1);
    dash_in = 1'b1;
    rise_n = 0;
    cyc();
    if (!tx_on) bad_n++;
    chk("rekey_ha_1cyc", int'(hang_active), 1);
    rise_n += int'(key_rise);
    cyc();
    if (!tx_on) bad_n++;
    chk("rekey_ha_2cyc", int'(hang_active), 0);
    rise_n += int'(key_rise);
    repeat (3) begin
      cyc();
      if (!tx_on) bad_n++;
      rise_n += int'(key_rise);
    end
    chk("rekey_tx_gap", bad_n, 0);
    chk("rekey_rise_n", rise_n, 1);
    dash_in = 1'b0;
    ha_n = 0;
    repeat (40) begin
      cyc();
      ha_n += int'(hang_active);
    end
    chk("rekey_reload_cycles", ha_n, 20);

    // hang_ms change mid-HANG is ignored.
    hang_ms = 8'd3;
    ptt_in = 1'b1;
    repeat (3) cyc();
    ptt_in = 1'b0;
    ha_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) hang_ms = 8'd200;
      cyc();
      ha_n += int'(hang_active);
    end
    chk("hang_change_cycles", ha_n, 12);

    // Async reset mid-HANG.
    hang_ms = 8'd5;
    ptt_in = 1'b1;
    repeat (3) cyc();
    ptt_in = 1'b0;
    repeat (8) cyc();
    chk("pre_reset_ha", int'(hang_active), 1);
    chk("pre_reset_hang_cnt_nz", int'(dut.hang_cnt != 8'd0), 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 0);
    chk("async_rst_hang_cnt", int'(dut.hang_cnt), 0);
    chk("async_rst_presc", int'(dut.u_presc.cnt), 0);
    ptt_in = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst2_rel+1_tx", int'(tx_on), 0);
    cyc();
    chk("rst2_rel+2_tx", int'(tx_on), 1);
    chk("rst2_rel+2_rise", int'(key_rise), 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  ptt_in  = ~ptt_in;
      if ($urandom_range(0, 9) == 0)  dot_in  = ~dot_in;
      if ($urandom_range(0, 9) == 0)  dash_in = ~dash_in;
      if ($urandom_range(0, 19) == 0) hang_ms = 8'($urandom_range(0, 3));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
